// File: rtl/player_motion.sv
`default_nettype none
// ============================================================================
// Module   : player_motion (+ player_motion_axis)
// Brief    : Push-buttons to player sprite position on a 96x64 OLED, with
//            step-on-press, hold-delay auto-repeat, clamping and respawn.
//            Optional macro WRAP_PLAYFIELD_EN wraps at the playfield edges.
// Revision : 1.0 - initial release
// ============================================================================

module player_motion_axis #(
    parameter int REPEAT_DELAY  = 3,
    parameter int REPEAT_PERIOD = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic respawn,
    input  logic btn_inc,
    input  logic btn_dec,
    output logic step_inc,
    output logic step_dec,
    output logic active
);
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] c_DELAY  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] c_PERIOD = CNT_W'(REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] c_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2,
        S_LOCK   = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_dir_inc, w_dir_inc_nxt;
    logic             w_inc, w_dec, w_any, w_reversed, w_step;

    // Both buttons held cancel each other out
    assign w_inc      = btn_inc & ~btn_dec;
    assign w_dec      = btn_dec & ~btn_inc;
    assign w_any      = w_inc | w_dec;
    assign w_reversed = w_any & (w_inc != r_dir_inc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_dir_inc <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_dir_inc <= w_dir_inc_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_dir_inc_nxt = r_dir_inc;
        w_step        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_step        = 1'b1;
                    w_cnt_nxt     = c_DELAY;
                    w_dir_inc_nxt = w_inc;
                    w_state_nxt   = S_DELAY;
                end
            end
            S_DELAY, S_REPEAT: begin
                if (!w_any) begin
                    w_state_nxt = S_IDLE;
                end else if (w_reversed) begin
                    w_step        = 1'b1;
                    w_cnt_nxt     = c_DELAY;
                    w_dir_inc_nxt = w_inc;
                    w_state_nxt   = S_DELAY;
                end else if (tick) begin
                    if (r_cnt <= c_ONE) begin
                        w_step      = 1'b1;
                        w_cnt_nxt   = c_PERIOD;
                        w_state_nxt = S_REPEAT;
                    end else begin
                        w_cnt_nxt = r_cnt - c_ONE;
                    end
                end
            end
            S_LOCK: begin
                if (!w_any) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Respawn wins over any step decided this cycle
        if (respawn) begin
            w_state_nxt = S_LOCK;
            w_step      = 1'b0;
        end
    end

    assign step_inc = w_step & w_inc;
    assign step_dec = w_step & w_dec;
    assign active   = (r_state == S_DELAY) || (r_state == S_REPEAT);
endmodule

module player_motion #(
    parameter int SCREEN_W      = 96,
    parameter int SCREEN_H      = 64,
    parameter int PLAYER_W      = 3,
    parameter int PLAYER_H      = 8,
    parameter int SPAWN_X       = 46,
    parameter int SPAWN_Y       = 28,
    parameter int TICK_DIV      = 1000000,
    parameter int REPEAT_DELAY  = 3,
    parameter int REPEAT_PERIOD = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_u,
    input  logic        btn_d,
    input  logic        btn_l,
    input  logic        btn_r,
    input  logic        respawn,
    output logic [63:0] player_locx,
    output logic [63:0] player_locy,
    output logic        moving
);
    localparam int XW = $clog2(SCREEN_W);
    localparam int YW = $clog2(SCREEN_H);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [XW-1:0] c_X_MAX     = XW'(SCREEN_W - PLAYER_W);
    localparam logic [YW-1:0] c_Y_MAX     = YW'(SCREEN_H - PLAYER_H);
    localparam logic [XW-1:0] c_SPAWN_X   = XW'(SPAWN_X);
    localparam logic [YW-1:0] c_SPAWN_Y   = YW'(SPAWN_Y);
    localparam logic [XW-1:0] c_X_ONE     = XW'(1);
    localparam logic [YW-1:0] c_Y_ONE     = YW'(1);
    localparam logic [PW-1:0] c_TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] c_P_ONE     = PW'(1);
`ifdef WRAP_PLAYFIELD_EN
    localparam bit c_WRAP = 1'b1;
`else
    localparam bit c_WRAP = 1'b0;
`endif

    // Button vectors are ordered {u, d, l, r}
    logic [3:0]    r_sync1, r_sync2;
    logic [PW-1:0] r_presc;
    logic          w_tick;
    logic [XW-1:0] r_x, w_x_nxt;
    logic [YW-1:0] r_y, w_y_nxt;
    logic          w_x_inc, w_x_dec, w_y_inc, w_y_dec, w_act_x, w_act_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {btn_u, btn_d, btn_l, btn_r};
            r_sync2 <= r_sync1;
        end
    end

    assign w_tick = (r_presc == c_TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_P_ONE;
        end
    end

    player_motion_axis #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_axis_x (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (w_tick),
        .respawn  (respawn),
        .btn_inc  (r_sync2[0]),
        .btn_dec  (r_sync2[1]),
        .step_inc (w_x_inc),
        .step_dec (w_x_dec),
        .active   (w_act_x)
    );

    player_motion_axis #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_axis_y (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (w_tick),
        .respawn  (respawn),
        .btn_inc  (r_sync2[2]),
        .btn_dec  (r_sync2[3]),
        .step_inc (w_y_inc),
        .step_dec (w_y_dec),
        .active   (w_act_y)
    );

    // A step past an edge either holds or wraps to the opposite edge
    always_comb begin
        w_x_nxt = r_x;
        if (w_x_inc) begin
            w_x_nxt = (r_x == c_X_MAX) ? (c_WRAP ? '0 : c_X_MAX) : r_x + c_X_ONE;
        end else if (w_x_dec) begin
            w_x_nxt = (r_x == '0) ? (c_WRAP ? c_X_MAX : '0) : r_x - c_X_ONE;
        end
    end

    always_comb begin
        w_y_nxt = r_y;
        if (w_y_inc) begin
            w_y_nxt = (r_y == c_Y_MAX) ? (c_WRAP ? '0 : c_Y_MAX) : r_y + c_Y_ONE;
        end else if (w_y_dec) begin
            w_y_nxt = (r_y == '0) ? (c_WRAP ? c_Y_MAX : '0) : r_y - c_Y_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= c_SPAWN_X;
            r_y <= c_SPAWN_Y;
        end else if (respawn) begin
            r_x <= c_SPAWN_X;
            r_y <= c_SPAWN_Y;
        end else begin
            r_x <= w_x_nxt;
            r_y <= w_y_nxt;
        end
    end

    assign player_locx = {{(64-XW){1'b0}}, r_x};
    assign player_locy = {{(64-YW){1'b0}}, r_y};
    assign moving      = w_act_x | w_act_y;
endmodule

`default_nettype wire
